// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and runs a single-outstanding request/response
// handshake to instruction memory, feeding the IF/ID register with instr and PC+4.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_next,
  output logic        if_wr_en,
  output logic        if_flush,
  output logic [31:0] fetch_pc
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] hold_instr_reg, hold_instr_next;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        deliver;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign pc_plus4        = pc_reg + 32'd4;

  always_comb begin
    deliver  = 1'b0;
    if_instr = 32'd0;
    case (state_reg)
      ST_WAIT: begin
        deliver  = imem_rvalid & ~stall & ~redirect_valid;
        if_instr = imem_rdata;
      end
      ST_HOLD: begin
        deliver  = ~stall & ~redirect_valid;
        if_instr = hold_instr_reg;
      end
      default: begin
        deliver  = 1'b0;
        if_instr = 32'd0;
      end
    endcase
    // Gating with reset keeps the bubble outputs correct while reset is held.
    deliver = deliver & reset;
  end

  assign if_pc_next = pc_plus4;
  assign if_flush   = ~deliver;
  assign if_wr_en   = ~stall | redirect_valid | ~reset;
  assign imem_req   = (state_reg == ST_REQ) & ~redirect_valid & reset;
  assign imem_addr  = pc_reg;
  assign fetch_pc   = pc_reg;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    hold_instr_next = hold_instr_reg;
    case (state_reg)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
        end else if (imem_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            pc_next    = redirect_target;
            state_next = ST_REQ;
          end else if (stall) begin
            hold_instr_next = imem_rdata;
            state_next      = ST_HOLD;
          end else begin
            pc_next    = pc_plus4;
            state_next = ST_REQ;
          end
        end else if (redirect_valid) begin
          // Response is still in flight; it must be swallowed before refetching.
          pc_next    = redirect_target;
          state_next = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = ST_REQ;
        end else if (!stall) begin
          pc_next    = pc_plus4;
          state_next = ST_REQ;
        end
      end
      default: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
        if (imem_rvalid) begin
          state_next = ST_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_REQ;
      pc_reg         <= RESET_PC_ALIGNED;
      hold_instr_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      hold_instr_reg <= hold_instr_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected deliveries are queued by the stimulus
// and popped by an independent monitor whenever IF/ID is written with a real instruction.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc_next;
  logic        if_wr_en;
  logic        if_flush;
  logic [31:0] fetch_pc;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcn;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_instr       (if_instr),
    .if_pc_next     (if_pc_next),
    .if_wr_en       (if_wr_en),
    .if_flush       (if_flush),
    .fetch_pc       (fetch_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: apply inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    imem_ready     = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    stall          = st;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic expect_deliver(input logic [31:0] instr, input logic [31:0] pcn);
    exp_t e;
    e.instr = instr;
    e.pcn   = pcn;
    exp_q.push_back(e);
  endtask

  // Monitor: a delivery is any cycle where IF/ID takes a non-bubble instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && if_flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_deliver: got instr=%h pc_next=%h required none", if_instr, if_pc_next);
        end else begin
          e = exp_q.pop_front();
          $display("deliver instr=%h pc_next=%h wr_en=%b", if_instr, if_pc_next, if_wr_en);
          chk("deliver_instr", if_instr, e.instr);
          chk("deliver_pc_next", if_pc_next, e.pcn);
          chk("deliver_wr_en", {31'd0, if_wr_en}, 32'd1);
        end
      end
    end
  end

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;

    #3;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_flush", {31'd0, if_flush}, 32'd1);
    chk("rst_wr_en", {31'd0, if_wr_en}, 32'd1);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc_next", if_pc_next, 32'd4);
    reset = 1'b1;

    // Sequential fetch from 0 and 4 with a 0-wait memory.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      chk("seq_req", {31'd0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, 32'(i * 4));
      chk("seq_flush_req", {31'd0, if_flush}, 32'd1);
      expect_deliver(32'h100 + 32'(i * 4), 32'(i * 4 + 4));
      drive(1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 32'd0);
    end

    // Response at pc=8 arrives under a 3-cycle stall.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("stall_addr", imem_addr, 32'h8);
    expect_deliver(32'h108, 32'hC);
    drive(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 32'd0);
    chk("stall_wr_en", {31'd0, if_wr_en}, 32'd0);
    chk("stall_flush", {31'd0, if_flush}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      chk("hold_wr_en", {31'd0, if_wr_en}, 32'd0);
      chk("hold_flush", {31'd0, if_flush}, 32'd1);
      chk("hold_pc", fetch_pc, 32'h8);
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Redirect to 0x43 while waiting: outstanding response must be dropped.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("after_hold_addr", imem_addr, 32'hC);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h43);
    chk("wait_redir_flush", {31'd0, if_flush}, 32'd1);
    chk("wait_redir_wr_en", {31'd0, if_wr_en}, 32'd1);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    chk("drop_flush", {31'd0, if_flush}, 32'd1);
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("drop_next_addr", imem_addr, 32'h40);

    // Redirect coincident with rvalid in WAIT.
    drive(1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'h80);
    chk("rv_redir_flush", {31'd0, if_flush}, 32'd1);
    chk("rv_redir_wr_en", {31'd0, if_wr_en}, 32'd1);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rv_redir_addr", imem_addr, 32'h80);

    // Redirect under stall while HOLDing: held word is discarded.
    drive(1'b0, 1'b1, 32'h180, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("hold_redir_wr_en", {31'd0, if_wr_en}, 32'd1);
    chk("hold_redir_flush", {31'd0, if_flush}, 32'd1);

    // Wrap-around at the top of the address space.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    expect_deliver(32'h1234_5678, 32'h0);
    drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc_next", if_pc_next, 32'h0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h200);
    chk("wrap_next_pc", fetch_pc, 32'h0);
    chk("redir_req_low", {31'd0, imem_req}, 32'd0);

    // Reset asserted while a request is outstanding.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("pre_rst_addr", imem_addr, 32'h200);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    reset      = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", fetch_pc, 32'h0);
    chk("midrst_flush", {31'd0, if_flush}, 32'd1);
    chk("midrst_wr_en", {31'd0, if_wr_en}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 32'd0);
    chk("late_rv_req", {31'd0, imem_req}, 32'd1);
    chk("late_rv_flush", {31'd0, if_flush}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("late_rv_still_req", {31'd0, imem_req}, 32'd1);
    chk("late_rv_addr", imem_addr, 32'h0);

    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("pending_deliveries", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC register and runs a single-outstanding request/response handshake to instruction memory.
- Delivers each fetched instruction and its PC+4 to IF/ID.
- Drives the IF/ID write-enable and flush (bubble) controls, and absorbs hazard stalls and branch/jump/exception redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- stall  input  1  hazard unit holds the front end.
- redirect_valid  input  1  a later stage requests a PC change this cycle.
- redirect_pc  input  32  new PC; bits [1:0] forced to 0 internally.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  32  word address of the request (= pc).
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  response instruction word.
- if_instr  output  32  instruction to IF/ID instr_in.
- if_pc_next  output  32  PC+4 of the delivered instruction, to IF/ID pc_next_in.
- if_wr_en  output  1  IF/ID write enable.
- if_flush  output  1  IF/ID flush; loads a NOP bubble.
- fetch_pc  output  32  current pc register, for exception EPC capture.

Behaviour:
- Registered state:
  - pc (32)
  - hold_instr (32)
  - state, one of REQ, WAIT, HOLD, DROP
- Reset (reset=0, asynchronous): pc=RESET_PC, hold_instr=0, state=REQ. During reset all outputs are combinationally:
  - imem_req=0
  - if_flush=1
  - if_wr_en=1
  - if_instr=0
  - if_pc_next=RESET_PC+4
- Delivery and control outputs:
  - "deliver" = (state==WAIT & imem_rvalid & ~stall & ~redirect_valid) | (state==HOLD & ~stall & ~redirect_valid).
  - if_instr = imem_rdata in WAIT, hold_instr in HOLD, 0 otherwise.
  - if_pc_next = pc+4, computed modulo 2^32.
  - if_flush = ~deliver.
  - if_wr_en = ~stall | redirect_valid, so a redirect flushes IF/ID even while stalled.
- imem_req = (state==REQ) & ~redirect_valid & reset; imem_addr = pc.
- REQ:
  - redirect_valid: pc<=redirect_pc & ~3, stay REQ.
  - else imem_ready: ->WAIT.
  - else stay REQ. Stall does not block issuing a request.
- WAIT:
  - rvalid & redirect_valid: discard data, pc<=redirect_pc, ->REQ.
  - rvalid & stall: hold_instr<=imem_rdata, ->HOLD.
  - rvalid otherwise: deliver, pc<=pc+4, ->REQ.
  - no rvalid & redirect_valid: pc<=redirect_pc, ->DROP.
  - no rvalid otherwise: stay WAIT.
- HOLD:
  - redirect_valid: pc<=redirect_pc, ->REQ (held word dropped).
  - else ~stall: deliver, pc<=pc+4, ->REQ.
  - else stay HOLD.
- DROP: the outstanding response is stale.
  - redirect_valid updates pc (last redirect wins).
  - imem_rvalid: discard data, ->REQ.
- Other inputs:
  - imem_rvalid in REQ or HOLD is ignored.
  - imem_ready outside REQ is ignored.
- Latency and throughput:
  - With a 0-wait memory (ready in the request cycle, rvalid next cycle), delivery occurs 1 cycle after acceptance.
  - Peak throughput is 1 instruction per 2 cycles. Overlapped fetch is out of scope.
- Reset asserted mid-transaction abandons it; a late rvalid after reset release arrives in REQ and is ignored.

Test Plan:
- Reset release, RESET_PC=0, 0-wait memory returning addr+0x100 → imem_addr sequence 0,4,8; if_instr 0x100,0x104,0x108 with if_pc_next 4,8,C; if_flush=1 on every non-delivery cycle.
- Response at pc=8 arrives while stall=1 for 3 cycles → state HOLD; if_wr_en=0; the word is delivered on the first cycle with stall=0; pc then becomes C.
- redirect_valid with redirect_pc=0x0000_0043 while in WAIT with no rvalid → DROP; the next rvalid is discarded with if_flush=1; the next imem_addr is 0x40.
- Redirect in the same cycle as rvalid in WAIT → data discarded; if_flush=1; if_wr_en=1; next request at the redirect target.
- redirect_valid=1 while stall=1 in HOLD → if_wr_en=1, if_flush=1, held word dropped, fetch restarts at the target.
- pc=0xFFFF_FFFC delivered → if_pc_next=0 and next imem_addr=0 (wrap-around); reset asserted during WAIT → imem_req=0 immediately and pc=RESET_PC.
